// File: rtl/bitwise_inverter_8b.sv
// Registered controlled inverter: output_z = input_a ^ {WIDTH{input_enable}}, 1-cycle latency.
// No backpressure: one result per in_valid cycle; output_z holds while in_valid is low.
module bitwise_inverter_8b #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_a,
  input  logic             input_enable,
  input  logic             in_valid,
  output logic [WIDTH-1:0] output_z,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] r_z;
  logic             r_vld;

  assign w_nxt = input_a ^ {WIDTH{input_enable}};

  // w_nxt is only consumed under in_valid, so X/Z on idle cycles never reaches r_z.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_z   <= RST_VAL;
      r_vld <= 1'b0;
    end else if (in_valid) begin
      r_z   <= w_nxt;
      r_vld <= 1'b1;
    end else begin
      r_vld <= 1'b0;
    end
  end

  assign output_z  = r_z;
  assign out_valid = r_vld;

endmodule

// File: tb/tb_bitwise_inverter_8b.sv
// Scoreboard bench for bitwise_inverter_8b: expected values queued at drive time,
// popped and compared one clock later when out_valid is expected.
module tb_bitwise_inverter_8b;

  logic       clk;
  logic       rst;
  logic [7:0] input_a;
  logic       input_enable;
  logic       in_valid;
  logic [7:0] output_z;
  logic       out_valid;

  logic [7:0] exp_q[$];
  logic [7:0] m_z;
  logic       m_vld;
  int         tests_run;
  int         tests_failed;

  bitwise_inverter_8b #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_enable (input_enable),
    .in_valid     (in_valid),
    .output_z     (output_z),
    .out_valid    (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog expired");
  end

  // Drive one cycle at the falling edge, update the model, then step past the rising edge.
  task automatic drive(input logic r, input logic [7:0] a, input logic en, input logic v);
    @(negedge clk);
    rst          = r;
    input_a      = a;
    input_enable = en;
    in_valid     = v;
    if (r) begin
      exp_q.delete();
      m_z   = 8'h00;
      m_vld = 1'b0;
    end else if (v) begin
      exp_q.push_back(a ^ {8{en}});
      m_vld = 1'b1;
    end else begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'h5A, 1'b1, 1'b1);
      tests_run++;
      if (output_z !== 8'h00 || out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset[%0d]: got z=%h vld=%b, want z=00 vld=0", i, output_z, out_valid);
      end
    end
  endtask

  task automatic test_passthrough();
    logic [7:0] a_tab[3] = '{8'h00, 8'hFF, 8'hA5};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, a_tab[i], 1'b0, 1'b1);
      if (m_vld) m_z = exp_q.pop_front();
      tests_run++;
      if (output_z !== m_z || out_valid !== m_vld) begin
        tests_failed++;
        $display("FAIL passthrough a=%h: got z=%h vld=%b, want z=%h vld=%b",
                 a_tab[i], output_z, out_valid, m_z, m_vld);
      end
    end
  endtask

  task automatic test_invert();
    logic [7:0] a_tab[3] = '{8'h00, 8'hFF, 8'hA5};
    logic [7:0] z_tab[3] = '{8'hFF, 8'h00, 8'h5A};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, a_tab[i], 1'b1, 1'b1);
      if (m_vld) m_z = exp_q.pop_front();
      tests_run++;
      if (output_z !== z_tab[i] || output_z !== m_z || out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL invert a=%h: got z=%h vld=%b, want z=%h vld=1",
                 a_tab[i], output_z, out_valid, z_tab[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Same operand, only input_enable toggles each cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'hA5, logic'(i % 2 == 0), 1'b1);
      if (m_vld) m_z = exp_q.pop_front();
      tests_run++;
      if (output_z !== m_z || out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: got z=%h vld=%b, want z=%h vld=1",
                 i, output_z, out_valid, m_z);
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 8'h3C, 1'b0, 1'b1);
    if (m_vld) m_z = exp_q.pop_front();
    tests_run++;
    if (output_z !== 8'h3C || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_load: got z=%h vld=%b, want z=3c vld=1", output_z, out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b0, 8'hFF, 1'b1, 1'b0);
      else       drive(1'b0, 8'hxx, 1'bx, 1'b0);
      if (m_vld) m_z = exp_q.pop_front();
      tests_run++;
      if (output_z !== 8'h3C || out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold[%0d]: got z=%h vld=%b, want z=3c vld=0", i, output_z, out_valid);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b0, 8'h77, 1'b0, 1'b1);
    if (m_vld) m_z = exp_q.pop_front();
    drive(1'b1, 8'h12, 1'b0, 1'b1);
    tests_run++;
    if (output_z !== 8'h00 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_midstream: got z=%h vld=%b, want z=00 vld=0", output_z, out_valid);
    end
    drive(1'b0, 8'h12, 1'b0, 1'b0);
    tests_run++;
    if (output_z !== 8'h00 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got z=%h vld=%b, want z=00 vld=0", output_z, out_valid);
    end
    drive(1'b0, 8'h12, 1'b1, 1'b1);
    if (m_vld) m_z = exp_q.pop_front();
    tests_run++;
    if (output_z !== 8'hED || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_first: got z=%h vld=%b, want z=ed vld=1", output_z, out_valid);
    end
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 256; a++) begin
      for (int e = 0; e < 2; e++) begin
        drive(1'b0, 8'(a), e[0], 1'b1);
        if (m_vld) m_z = exp_q.pop_front();
        tests_run++;
        if (output_z !== m_z || out_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL sweep a=%h en=%0d: got z=%h vld=%b, want z=%h vld=1",
                   8'(a), e, output_z, out_valid, m_z);
        end
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tests_run++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL sweep_drain: got queue=%0d vld=%b, want queue=0 vld=0",
               exp_q.size(), out_valid);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    m_z          = 8'h00;
    m_vld        = 1'b0;
    rst          = 1'b1;
    input_a      = 8'h00;
    input_enable = 1'b0;
    in_valid     = 1'b0;

    test_reset();
    test_passthrough();
    test_invert();
    test_back_to_back();
    test_hold();
    test_reset_midstream();
    test_sweep();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
